// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single DataMemory port between two requesters (port 0: CPU
//   load/store, port 1: IO/loader DMA). Round-robin arbitration when both ask
//   at once, one transaction in flight, req/ack handshake. Each access runs
//   IDLE -> ACCESS -> (load: WAIT) -> ACK -> IDLE.
//
//   state  | meaning
//   IDLE   | sample requests, latch winner's command
//   ACCESS | drive address/size/data, pulse write enable or start read
//   WAIT   | hold read command while the registered read matures
//   ACK    | one-cycle ack to the granted port, memory idle
//
// Ports
//   clk, rst          clock, async active-high reset
//   m{0,1}_req/we/addr/wdata/size  requester command, held until ack
//   m{0,1}_ack        one-cycle completion pulse
//   m{0,1}_rdata      last load result for that port
//   mem_*             DataMemory interface (mem_out is the read return)
module dmem_port_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_size,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_size,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  mem_data_size,
  input  logic [31:0] mem_out
);

  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] RL_CNT = CW'(READ_LATENCY);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          gnt_q, gnt_d;
  logic          cmd_we_q, cmd_we_d;
  logic [31:0]   cmd_addr_q, cmd_addr_d;
  logic [31:0]   cmd_wdata_q, cmd_wdata_d;
  logic [2:0]    cmd_size_q, cmd_size_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_size_d  = cmd_size_q;
    cnt_d       = cnt_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // Contention goes to the rr pointer; a lone request does not move it.
          if (m0_req && m1_req) begin
            gnt_d = rr_q;
            rr_d  = ~rr_q;
          end else begin
            gnt_d = m1_req;
          end
          cmd_we_d    = gnt_d ? m1_we    : m0_we;
          cmd_addr_d  = gnt_d ? m1_addr  : m0_addr;
          cmd_wdata_d = gnt_d ? m1_wdata : m0_wdata;
          cmd_size_d  = gnt_d ? m1_size  : m0_size;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cmd_we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = RL_CNT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (gnt_q) rdata1_d = mem_out;
          else       rdata0_d = mem_out;
          state_d = S_ACK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_size_q  <= '0;
      cnt_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_size_q  <= cmd_size_d;
      cnt_q       <= cnt_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Address and size stay up through WAIT: the memory extends mem_out
  // combinationally from mem_data_size.
  always_comb begin
    m0_ack          = (state_q == S_ACK) && !gnt_q;
    m1_ack          = (state_q == S_ACK) &&  gnt_q;
    m0_rdata        = rdata0_q;
    m1_rdata        = rdata1_q;
    mem_access_addr = '0;
    mem_in          = '0;
    mem_data_size   = '0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    if (state_q == S_ACCESS || state_q == S_WAIT) begin
      mem_access_addr = cmd_addr_q;
      mem_data_size   = cmd_size_q;
    end
    if (state_q == S_ACCESS) begin
      mem_in       = cmd_wdata_q;
      mem_write_en = cmd_we_q;
      mem_read_en  = !cmd_we_q;
    end
    if (state_q == S_WAIT) mem_read_en = 1'b1;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index = inst*2 + port ; inst 0 has READ_LATENCY=1, inst 1 has READ_LATENCY=2
  logic [3:0]  req_v, we_v, ack_v;
  logic [31:0] addr_v [4];
  logic [31:0] wdata_v [4];
  logic [31:0] rdata_v [4];
  logic [2:0]  size_v [4];

  logic [31:0] maddr [2];
  logic [31:0] min [2];
  logic [31:0] mout [2];
  logic [2:0]  msize [2];
  logic [1:0]  mwe, mre;

  int rl_of [2] = '{1, 2};

  dmem_port_arbiter #(.READ_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(req_v[0]), .m0_we(we_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
    .m0_size(size_v[0]), .m0_ack(ack_v[0]), .m0_rdata(rdata_v[0]),
    .m1_req(req_v[1]), .m1_we(we_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
    .m1_size(size_v[1]), .m1_ack(ack_v[1]), .m1_rdata(rdata_v[1]),
    .mem_access_addr(maddr[0]), .mem_in(min[0]), .mem_write_en(mwe[0]),
    .mem_read_en(mre[0]), .mem_data_size(msize[0]), .mem_out(mout[0])
  );

  dmem_port_arbiter #(.READ_LATENCY(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(req_v[2]), .m0_we(we_v[2]), .m0_addr(addr_v[2]), .m0_wdata(wdata_v[2]),
    .m0_size(size_v[2]), .m0_ack(ack_v[2]), .m0_rdata(rdata_v[2]),
    .m1_req(req_v[3]), .m1_we(we_v[3]), .m1_addr(addr_v[3]), .m1_wdata(wdata_v[3]),
    .m1_size(size_v[3]), .m1_ack(ack_v[3]), .m1_rdata(rdata_v[3]),
    .mem_access_addr(maddr[1]), .mem_in(min[1]), .mem_write_en(mwe[1]),
    .mem_read_en(mre[1]), .mem_data_size(msize[1]), .mem_out(mout[1])
  );

  // Memory model: byte-addressed little-endian, registered read pipeline,
  // combinational extension on mem_data_size.
  logic [7:0]  ram [2][1024];
  logic [31:0] pipe [2][2];

  function automatic int nbytes(input logic [2:0] s);
    if (s[1:0] == 2'b00) return 1;
    if (s[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] r, input logic [2:0] s);
    case (s)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'h0, r[7:0]};
      3'b101:  return {16'h0, r[15:0]};
      default: return r;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mwe[i]) begin
        for (int b = 0; b < 4; b++)
          if (b < nbytes(msize[i])) ram[i][10'(maddr[i] + 32'(b))] <= min[i][8*b +: 8];
      end
      if (mre[i])
        pipe[i][0] <= {ram[i][10'(maddr[i] + 32'd3)], ram[i][10'(maddr[i] + 32'd2)],
                       ram[i][10'(maddr[i] + 32'd1)], ram[i][10'(maddr[i])]};
      pipe[i][1] <= pipe[i][0];
    end
  end

  assign mout[0] = ext(pipe[0][0], msize[0]);
  assign mout[1] = ext(pipe[1][1], msize[1]);

  // Scoreboard
  typedef struct {
    int          port;
    bit          ld;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t sbq [2][$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor
  logic [31:0] shadow [2][2];
  int we_cnt [2], re_cnt [2], st_done [2], ld_done [2];
  exp_t mon_e;
  int mon_p;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        shadow[i][0] = '0; shadow[i][1] = '0;
        we_cnt[i] = 0; re_cnt[i] = 0; st_done[i] = 0; ld_done[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mwe[i]) we_cnt[i]++;
        if (mre[i]) re_cnt[i]++;
        if (ack_v[2*i] || ack_v[2*i+1]) begin
          chk("ack_overlap", 32'(ack_v[2*i] & ack_v[2*i+1]), 32'd0);
          mon_p = ack_v[2*i+1] ? 1 : 0;
          if (sbq[i].size() == 0) begin
            chk("unexpected_ack", 32'(mon_p + 1), 32'd0);
          end else begin
            mon_e = sbq[i].pop_front();
            chk("ack_port", 32'(mon_p), 32'(mon_e.port));
            chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            if (mon_e.ld) begin
              shadow[i][mon_e.port] = mon_e.rd;
              ld_done[i]++;
              chk("read_en_cycles", 32'(re_cnt[i]), 32'(ld_done[i] * (1 + rl_of[i])));
            end else begin
              st_done[i]++;
              chk("write_en_cycles", 32'(we_cnt[i]), 32'(st_done[i]));
            end
            chk("rdata_p0", rdata_v[2*i], shadow[i][0]);
            chk("rdata_p1", rdata_v[2*i+1], shadow[i][1]);
          end
        end
      end
    end
  end

  task automatic issue(input int inst, input int port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] sz, input logic [31:0] exp_rd);
    int ix;
    exp_t e;
    bit got;
    ix = inst * 2 + port;
    @(posedge clk); #1;
    req_v[ix] = 1'b1; we_v[ix] = we; addr_v[ix] = addr; wdata_v[ix] = wd; size_v[ix] = sz;
    e.port = port; e.ld = !we; e.rd = exp_rd;
    e.cyc = cyc + 2 + (we ? 0 : rl_of[inst]);
    sbq[inst].push_back(e);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = ack_v[ix];
    end
    chk("ack_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_v[ix] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_acks"}, 32'(ack_v[1:0]), 32'd0);
    chk({tag, "_rdata0"}, rdata_v[0], 32'd0);
    chk({tag, "_rdata1"}, rdata_v[1], 32'd0);
    chk({tag, "_maddr"}, maddr[0], 32'd0);
    chk({tag, "_min"}, min[0], 32'd0);
    chk({tag, "_en"}, 32'({mwe[0], mre[0]}), 32'd0);
    chk({tag, "_size"}, 32'(msize[0]), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  int a0, a1, c0;
  bit d0, d1;
  exp_t e2;

  initial begin
    rst = 1'b1;
    req_v = '0; we_v = '0;
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = '0; wdata_v[i] = '0; size_v[i] = '0;
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 1024; j++) ram[i][j] = 8'h00;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: store then load on port 0
    issue(0, 0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0);
    issue(0, 0, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF);

    // 3: byte store on port 1, signed and unsigned reloads
    issue(0, 1, 1'b1, 32'h103, 32'h00000080, 3'b000, 32'h0);
    issue(0, 1, 1'b0, 32'h103, 32'h0, 3'b000, 32'hFFFFFF80);
    issue(0, 1, 1'b0, 32'h103, 32'h0, 3'b100, 32'h00000080);

    // 4: misaligned word store/load
    issue(0, 0, 1'b1, 32'h101, 32'h11223344, 3'b010, 32'h0);
    issue(0, 0, 1'b0, 32'h101, 32'h0, 3'b010, 32'h11223344);

    // 2: both ports held from reset
    pulse_reset();
    @(posedge clk); #1;
    req_v[1:0] = 2'b11; we_v[1:0] = 2'b11;
    addr_v[0] = 32'h200; wdata_v[0] = 32'hA0A0A0A0; size_v[0] = 3'b010;
    addr_v[1] = 32'h204; wdata_v[1] = 32'h5B5B5B5B; size_v[1] = 3'b010;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      e2.port = k % 2; e2.ld = 1'b0; e2.rd = '0; e2.cyc = c0 + 2 + 3 * k;
      sbq[0].push_back(e2);
    end
    a0 = 0; a1 = 0;
    for (int k = 0; k < 40 && (a0 < 2 || a1 < 2); k++) begin
      @(negedge clk);
      d0 = ack_v[0] && (a0 == 1);
      d1 = ack_v[1] && (a1 == 1);
      if (ack_v[0]) a0++;
      if (ack_v[1]) a1++;
      @(posedge clk); #1;
      if (d0) req_v[0] = 1'b0;
      if (d1) req_v[1] = 1'b0;
    end
    chk("rr_acks_p0", 32'(a0), 32'd2);
    chk("rr_acks_p1", 32'(a1), 32'd2);
    req_v[1:0] = 2'b00;
    issue(0, 1, 1'b0, 32'h200, 32'h0, 3'b010, 32'hA0A0A0A0);
    issue(0, 0, 1'b0, 32'h204, 32'h0, 3'b101, 32'h00005B5B);

    // 5: reset during WAIT of a load
    @(posedge clk); #1;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h100; size_v[0] = 3'b010;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_in_wait");
    req_v[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    // 0x100..0x103 now EF 44 33 22 after the misaligned store
    issue(0, 0, 1'b0, 32'h100, 32'h0, 3'b010, 32'h223344EF);

    // Reserved size code passes through as a word
    issue(0, 1, 1'b0, 32'h101, 32'h0, 3'b111, 32'h11223344);

    // 6: READ_LATENCY=2 instance
    issue(1, 1, 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, 32'h0);
    issue(1, 1, 1'b0, 32'h40, 32'h0, 3'b010, 32'hCAFEF00D);
    issue(1, 1, 1'b0, 32'h42, 32'h0, 3'b001, 32'hFFFFCAFE);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain_a", 32'(sbq[0].size()), 32'd0);
    chk("sb_drain_b", 32'(sbq[1].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
